tnoc_flit_if_slicer: RTL
========================

# tnoc_flit_if_slicer

Register slice for `tnoc_flit_if`, one per virtual channel, that breaks every combinational path between a flit producer and its consumer. It sits directly downstream of any flit initiator, such as a router output, a network-interface packer or the dummy initiator used for tied-off ports, and presents a fully registered initiator to the next stage. Each channel has a two-entry skid buffer, so per-channel throughput stays at one flit per cycle. On non-local ports, where the flit bus is shared across channels, a round-robin arbiter serialises buffered channels onto the single output flit lane.

## Interface

**Parameters**
- `CONFIG`, default `TNOC_DEFAULT_CONFIG`: NoC configuration, which sets flit width.
- `CHANNELS`, default `CONFIG.virtual_channels`: number of virtual channels.
- `PORT_TYPE`, default `TNOC_LOCAL_PORT`: port type.
  - Derived `FLITS = is_local_port(PORT_TYPE) ? CHANNELS : 1`.

**Ports**
- `clk`, input, 1 bit: the only clock.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `flit_in_if`, `tnoc_flit_if.target`, with fields:
  - `valid[CHANNELS]`
  - `ready[CHANNELS]`
  - `flit[FLITS]`
- `flit_out_if`, `tnoc_flit_if.initiator`, with the same fields as `flit_in_if`.

## Operation

**Per channel `c` state**
- `main_valid/main_flit`: the output register.
- `skid_valid/skid_flit`: the overflow register.

**Input side**
- `flit_in_if.ready[c] = !skid_valid[c]`. This is a register output, so there is no combinational path from the output side.
- An input transfer on channel `c` occurs when `valid[c] && ready[c]`.
- Input flit source:
  - Local port: `flit[c]`.
  - Non-local port: `flit[0]`. At most one input valid is asserted per cycle.

**Per-channel update on each clock edge**, where `pop = out transfer on c` and `push = in transfer on c`:
- **`main_valid` clear or popped, `push`:** the flit goes to main.
- **`main_valid` held (no pop), `push`:** the flit goes to skid, and ready drops next cycle.
- **`pop` with `skid_valid`:** skid moves to main and skid clears. A simultaneous push is impossible because ready is low.
- **`pop`, no skid, no push:** `main_valid` clears.
- **Simultaneous push and pop with skid empty:** the new flit replaces main. `main_valid` stays 1 and the skid stays empty.

**Output, local port**
- `flit_out_if.valid[c] = main_valid[c]`.
- `flit_out_if.flit[c] = main_flit[c]`.
- Channels are fully independent.

**Output, non-local port**
- A registered one-hot `grant[CHANNELS]` selects one channel.
- `flit_out_if.valid[c] = main_valid[c] & grant[c]`.
- `flit_out_if.flit[0] = main_flit[granted channel]`.
- **Grant hold:** the grant is held while the granted channel is valid and not ready. An offered flit is never withdrawn or changed until accepted.
- **Re-arbitration:** occurs after an output transfer, or when the granted channel has no valid flit. Round-robin starts from the channel after the last granted one and considers channels with `main_valid` set. With no requester, grant is all-zero.
- **Registration:** grant is registered, so a channel's flit first becomes visible on the output the cycle after it wins arbitration.

**Flow-control rules**
- Output valid/flit are stable from assertion until the transfer.
- Order within a channel is preserved.
- No flit is dropped or duplicated.

## Timing

**Reset values**, applied while `rst_n` is low and taking effect asynchronously:
- All `main_valid`, `skid_valid` and `grant` are 0.
- `flit_out_if.valid` = 0 and `flit_out_if.flit` = 0.
- `flit_in_if.ready` = all 1s. No flit is captured while `rst_n` is low.

**Reset mid-operation:** buffered flits are discarded. Outputs are at reset values from the cycle after `rst_n` asserts.

**Latency**
- Local port: 1 cycle from input transfer to output valid.
- Non-local port: 1 cycle if the channel is already granted or the output is idle and it wins arbitration in that same cycle, otherwise more.

**Throughput**
- Local port: 1 flit/cycle/channel.
- Non-local port: 1 flit/cycle aggregate.

**Backpressure:** after one cycle of output stall, one further input flit is absorbed into the skid. The input ready is deasserted in the following cycle.

## Configuration

- **`TNOC_FLIT_IF_SLICER_SVA_EN` defined:** bound-in assertions check the following:
  - Input valid/flit are stable while not ready.
  - On a non-local port, input valid is at most one-hot.
  - Output valid is one-hot (non-local).
  - There is no push into a channel with `skid_valid` set.
- **Undefined:** no assertion code is compiled. Functional RTL is identical in both cases.

## Test plan

- **Local, 4 channels, output `ready` held 1:** stream 0x10–0x1F on channel 2. The output shows the same sequence, 1-cycle delay, no bubbles. Input `ready[2]` stays 1.
- **Local, output `ready[0]=0` for 3 cycles during a stream on channel 0:** main holds A, skid holds B, and `ready[0]` drops on the cycle after B is accepted. On release, A, then B, then C follow back-to-back with no loss.
- **Non-local, 2 channels, flits buffered on both:**
  - Channel 0 holds 0xA0 and channel 1 holds 0xB0.
  - The last grant was channel 1.
  - Required output order: 0xA0 then 0xB0, with valid one-hot each cycle.
- **Non-local, output stalled while channel 1 is granted, channel 0 fills meanwhile:** the grant stays on 1 and the flit is unchanged until accepted, then moves to 0.
- **Assert `rst_n` low while both registers on channel 1 are full:** outputs go to valid=0/flit=0 and ready to all 1s. After release, new flits pass with no stale data.

Source files
------------

// File: rtl/tnoc_flit_if_slicer.sv
// Per-virtual-channel register slice with a two-entry skid buffer; non-local ports share one
// registered flit lane via round-robin. Define TNOC_FLIT_IF_SLICER_SVA_EN to compile assertions.
module tnoc_flit_if_slicer #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 2,
  parameter bit          LOCAL_PORT = 1'b1,
  localparam int unsigned FLITS     = LOCAL_PORT ? CHANNELS : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              flit_in_valid_i,
  output logic [CHANNELS-1:0]              flit_in_ready_o,
  input  logic [FLITS-1:0][FLIT_WIDTH-1:0] flit_in_flit_i,
  output logic [CHANNELS-1:0]              flit_out_valid_o,
  input  logic [CHANNELS-1:0]              flit_out_ready_i,
  output logic [FLITS-1:0][FLIT_WIDTH-1:0] flit_out_flit_o
);

  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]                 main_valid_q, main_valid_d;
  logic [CHANNELS-1:0]                 skid_valid_q, skid_valid_d;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] main_flit_q, main_flit_d;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] skid_flit_q, skid_flit_d;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 push, pop;

  if (LOCAL_PORT) begin : g_in_local
    assign in_flit = flit_in_flit_i;
  end else begin : g_in_shared
    assign in_flit = {CHANNELS{flit_in_flit_i[0]}};
  end

  // Ready comes straight from a register, so nothing downstream reaches the input side.
  assign flit_in_ready_o = ~skid_valid_q;
  assign push            = flit_in_valid_i & ~skid_valid_q;
  assign pop             = flit_out_valid_o & flit_out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_flit_d  = main_flit_q;
    skid_valid_d = skid_valid_q;
    skid_flit_d  = skid_flit_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (skid_valid_q[c]) begin
        if (pop[c]) begin
          main_flit_d[c]  = skid_flit_q[c];
          skid_valid_d[c] = 1'b0;
        end
      end else if (push[c]) begin
        if (!main_valid_q[c] || pop[c]) begin
          main_valid_d[c] = 1'b1;
          main_flit_d[c]  = in_flit[c];
        end else begin
          skid_valid_d[c] = 1'b1;
          skid_flit_d[c]  = in_flit[c];
        end
      end else if (pop[c]) begin
        main_valid_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= '0;
      main_flit_q  <= '0;
      skid_valid_q <= '0;
      skid_flit_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_flit_q  <= main_flit_d;
      skid_valid_q <= skid_valid_d;
      skid_flit_q  <= skid_flit_d;
    end
  end

  if (LOCAL_PORT) begin : g_out_local
    assign flit_out_valid_o = main_valid_q;
    assign flit_out_flit_o  = main_flit_q;
  end else begin : g_out_shared
    logic [CHANNELS-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  stalled;
    logic                  found;
    logic [IdxW-1:0]       idx;

    assign flit_out_valid_o   = main_valid_q & grant_q;
    assign flit_out_flit_o[0] = out_flit;
    assign stalled            = |(flit_out_valid_o & ~flit_out_ready_i);

    always_comb begin
      out_flit = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (grant_q[c]) out_flit = out_flit | main_flit_q[c];
      end
    end

    // Arbitrate on next-cycle occupancy so an idle lane shows a fresh flit one cycle later.
    always_comb begin
      grant_d = grant_q;
      last_d  = last_q;
      found   = 1'b0;
      idx     = '0;
      if (!stalled) begin
        grant_d = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
          idx = IdxW'((32'(last_q) + i) % CHANNELS);
          if (!found && main_valid_d[idx]) begin
            grant_d[idx] = 1'b1;
            last_d       = idx;
            found        = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_q <= '0;
        last_q  <= IdxW'(CHANNELS - 1);
      end else begin
        grant_q <= grant_d;
        last_q  <= last_d;
      end
    end
  end

`ifdef TNOC_FLIT_IF_SLICER_SVA_EN
  for (genvar c = 0; c < CHANNELS; c++) begin : g_sva
    assert property (@(posedge clk) disable iff (!rst_n)
      (flit_in_valid_i[c] && !flit_in_ready_o[c]) |=>
        (flit_in_valid_i[c] && $stable(in_flit[c])));
    assert property (@(posedge clk) disable iff (!rst_n)
      (flit_in_valid_i[c] && flit_in_ready_o[c]) |-> !skid_valid_q[c]);
  end
  if (!LOCAL_PORT) begin : g_sva_shared
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(flit_in_valid_i));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(flit_out_valid_o));
  end
`else
  // Assertions compiled out; functional logic above is unchanged.
`endif

endmodule
